// File: rtl/packer_lane.sv
// -----------------------------------------------------------------------------
// packer_lane
//
// Packs a packet of NumPacker+1 data, arriving up to LANES per beat, into one
// NUM_DATA*DATA_WIDTH word and presents that word behind a valid/ready pair.
// Sits between the on-chip buffer read port and the PE operand registers.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Ready (ReqDat) and valid (ValPacker) are pure
// decodes of the registered state, so neither depends on any input in the
// same cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   NumPacker  packet length minus 1, sampled with Sta
//   Sta        start pulse, honoured only in IDLE
//   Bypass     zero-data pulse, honoured only in IDLE, wins over Sta
//   Order      0 = shift-in (newest datum in field 0), 1 = datum j in field j
//   ReqDat     ready for an input beat (state FILL)
//   ValDat     input beat valid
//   DatLanes   beat data, lane 0 in the low bits and first in stream order
//   DatNum     number of valid lanes minus 1
//   DatPacker  packed word, field i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   ValPacker  packed word valid (state OUT)
//   RdyPacker  consumer accepts the word
//   Ovf        one-cycle pulse after a beat whose excess lanes were dropped
//   state_dbg  current FSM state (0 IDLE, 1 FILL, 2 OUT)
// -----------------------------------------------------------------------------
module packer_lane #(
  parameter int NUM_DATA   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  localparam int NPW = $clog2(NUM_DATA),
  localparam int DNW = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CW  = NPW + 1,
  localparam int WW  = NUM_DATA * DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NPW-1:0]              NumPacker,
  input  logic                        Sta,
  input  logic                        Bypass,
  input  logic                        Order,
  output logic                        ReqDat,
  input  logic                        ValDat,
  input  logic [DATA_WIDTH*LANES-1:0] DatLanes,
  input  logic [DNW-1:0]              DatNum,
  output logic [WW-1:0]               DatPacker,
  output logic                        ValPacker,
  input  logic                        RdyPacker,
  output logic                        Ovf,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   word_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   target_q;
  logic            order_q;
  logic            ovf_q;

  // Beat bookkeeping
  logic            fire;
  logic [CW-1:0]   beat_n;   // lanes offered this beat
  logic [CW-1:0]   rem;      // data still needed to complete the packet
  logic [CW-1:0]   take;     // lanes actually accepted
  logic [CW-1:0]   cnt_nxt;
  logic            excess;
  logic [WW-1:0]   word_fill;

  assign fire = ValDat && (state_q == S_FILL);

  always_comb begin
    beat_n = CW'(DatNum) + CW'(1);
    // DatNum can encode more lanes than exist when LANES is 1; clamp it.
    if (beat_n > CW'(LANES)) beat_n = CW'(LANES);
    rem     = target_q - cnt_q;
    take    = (beat_n < rem) ? beat_n : rem;
    cnt_nxt = cnt_q + take;
    excess  = beat_n > rem;
  end

  // Merge the accepted lanes of this beat into the word, in lane order.
  always_comb begin
    word_fill = word_q;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(take)) begin
        if (order_q) begin
          if (int'(cnt_q) + i < NUM_DATA)
            word_fill[(int'(cnt_q) + i)*DATA_WIDTH +: DATA_WIDTH] =
              DatLanes[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          // Shift-in: older data move up one field per new datum. The word
          // starts at zero and receives exactly Target shifts, so fields at or
          // above Target remain zero.
          word_fill = (word_fill << DATA_WIDTH) |
                      WW'(DatLanes[i*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Bypass)   state_d = S_OUT;
        else if (Sta) state_d = S_FILL;
      end
      S_FILL: begin
        if (fire && (cnt_nxt == target_q)) state_d = S_OUT;
      end
      S_OUT: begin
        if (RdyPacker) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ReqDat    = (state_q == S_FILL);
    ValPacker = (state_q == S_OUT);
    state_dbg = state_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q   <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      order_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Bypass) begin
            word_q <= '0;
          end else if (Sta) begin
            word_q   <= '0;
            cnt_q    <= '0;
            target_q <= CW'(NumPacker) + CW'(1);
            order_q  <= Order;
          end
        end
        S_FILL: begin
          if (fire) begin
            word_q <= word_fill;
            cnt_q  <= cnt_nxt;
            ovf_q  <= excess;
          end
        end
        default: ;
      endcase
    end
  end

  assign DatPacker = word_q;
  assign Ovf       = ovf_q;

endmodule
